// File: rtl/ind_pkg.sv
// Shared definitions for the indicator driver: control codes, FSM states,
// active-low 7-segment glyphs and the BCD-nibble to segment lookup.
package ind_pkg;

    localparam logic [2:0] CODE_P  = 3'd0;
    localparam logic [2:0] CODE_M  = 3'd1;
    localparam logic [2:0] CODE_D0 = 3'd2;
    localparam logic [2:0] CODE_D  = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_DONE
    } state_t;

    // Bit 7 is dp, left dark (1) in every glyph; bit 0 is segment a.
    localparam logic [7:0] GLYPH_0     = 8'b1100_0000;
    localparam logic [7:0] GLYPH_1     = 8'b1111_1001;
    localparam logic [7:0] GLYPH_2     = 8'b1010_0100;
    localparam logic [7:0] GLYPH_3     = 8'b1011_0000;
    localparam logic [7:0] GLYPH_4     = 8'b1001_1001;
    localparam logic [7:0] GLYPH_5     = 8'b1001_0010;
    localparam logic [7:0] GLYPH_6     = 8'b1000_0010;
    localparam logic [7:0] GLYPH_7     = 8'b1111_1000;
    localparam logic [7:0] GLYPH_8     = 8'b1000_0000;
    localparam logic [7:0] GLYPH_9     = 8'b1001_0000;
    localparam logic [7:0] GLYPH_E     = 8'b1000_0110;
    localparam logic [7:0] GLYPH_R     = 8'b1010_1111;
    localparam logic [7:0] GLYPH_BLANK = 8'b1111_1111;

    function automatic logic [7:0] bcd_to_seg(input logic [3:0] nib);
        logic [7:0] g;
        case (nib)
            4'd0:    g = GLYPH_0;
            4'd1:    g = GLYPH_1;
            4'd2:    g = GLYPH_2;
            4'd3:    g = GLYPH_3;
            4'd4:    g = GLYPH_4;
            4'd5:    g = GLYPH_5;
            4'd6:    g = GLYPH_6;
            4'd7:    g = GLYPH_7;
            4'd8:    g = GLYPH_8;
            4'd9:    g = GLYPH_9;
            default: g = GLYPH_BLANK;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/ind_driver_bin2bcd_seq.sv
// Sequential double-dabble converter: one bit per cycle, start/done handshake.
// state    | meaning
// ST_IDLE  | waiting for start_i, loads the binary operand
// ST_SHIFT | IND_1 adjust-and-shift cycles, down-counter tracks remaining bits
// ST_DONE  | bcd_o valid, done_o high for this one cycle
module bin2bcd_seq
    import ind_pkg::*;
#(
    parameter int IND_1  = 11,
    parameter int DIGITS = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  start_i,
    input  logic [IND_1-1:0]      bin_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [4*DIGITS-1:0]   bcd_o
);

    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(IND_1);

    state_t            state_q;
    logic [IND_1-1:0]  bin_q;
    logic [BW-1:0]     bcd_q;
    logic [BW-1:0]     adj_d;
    logic [CW-1:0]     cnt_q;

    always_comb begin
        adj_d = bcd_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) adj_d[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_IDLE;
            bin_q   <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            busy_o  <= 1'b0;
            done_o  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        bin_q   <= bin_i;
                        bcd_q   <= '0;
                        cnt_q   <= CW'(IND_1 - 1);
                        busy_o  <= 1'b1;
                        state_q <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    bcd_q <= {adj_d[BW-2:0], bin_q[IND_1-1]};
                    bin_q <= bin_q << 1;
                    if (cnt_q == '0) begin
                        done_o  <= 1'b1;
                        state_q <= ST_DONE;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                ST_DONE: begin
                    done_o  <= 1'b0;
                    busy_o  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bcd_o = bcd_q;

endmodule

// File: rtl/ind_driver.sv
// Multiplexed 7-segment indicator driver behind the calculator ALU.
// Optional IND_LEADING_ZERO_BLANK_EN blanks leading zero digits.
module ind_driver
    import ind_pkg::*;
#(
    parameter int IND_1    = 11,
    parameter int CONTROL  = 3,
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 16
) (
    input  logic                clk_IND,
    input  logic                rst_n_IND,
    input  logic [IND_1-1:0]    ind_1,
    input  logic [CONTROL-1:0]  control,
    output logic [7:0]          seg,
    output logic [DIGITS-1:0]   an,
    output logic                minus_led,
    output logic                busy
);

    localparam int BW = 4 * DIGITS;
    localparam int PW = $clog2(SCAN_DIV);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [IND_1-1:0]   cap_val_q;
    logic [CONTROL-1:0] cap_ctl_q;
    logic [BW-1:0]      dbcd_q;
    logic [2:0]         dctl_q;
    logic               minus_q;
    logic [PW-1:0]      presc_q;
    logic [IW-1:0]      idx_q;
    logic [7:0]         seg_q;
    logic [DIGITS-1:0]  an_q;

    logic               cvt_busy;
    logic               cvt_done;
    logic [BW-1:0]      cvt_bcd;
    logic               start;
    logic [2:0]         code_n;
    logic [3:0]         nib;
    logic               blank;
    logic [7:0]         glyph_d;

    // The converter only accepts a start while idle, so this is also the change gate.
    assign start = !cvt_busy && ({ind_1, control} != {cap_val_q, cap_ctl_q});

    bin2bcd_seq #(
        .IND_1  (IND_1),
        .DIGITS (DIGITS)
    ) u_bin2bcd (
        .clk_i   (clk_IND),
        .rst_n_i (rst_n_IND),
        .start_i (start),
        .bin_i   (ind_1),
        .busy_o  (cvt_busy),
        .done_o  (cvt_done),
        .bcd_o   (cvt_bcd)
    );

    always_comb begin
        code_n = CODE_P;
        if (cap_ctl_q == CONTROL'(CODE_M))       code_n = CODE_M;
        else if (cap_ctl_q == CONTROL'(CODE_D0)) code_n = CODE_D0;
        else if (cap_ctl_q == CONTROL'(CODE_D))  code_n = CODE_D;
    end

    always_ff @(posedge clk_IND or negedge rst_n_IND) begin
        if (!rst_n_IND) begin
            cap_val_q <= '0;
            cap_ctl_q <= '0;
            dbcd_q    <= '0;
            dctl_q    <= CODE_P;
            minus_q   <= 1'b0;
        end else begin
            if (start) begin
                cap_val_q <= ind_1;
                cap_ctl_q <= control;
            end
            if (cvt_done) begin
                dbcd_q  <= cvt_bcd;
                dctl_q  <= code_n;
                minus_q <= (code_n == CODE_M);
            end
        end
    end

    always_comb begin
        nib     = 4'd0;
        blank   = 1'b0;
        glyph_d = GLYPH_BLANK;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == IW'(i)) nib = dbcd_q[4*i +: 4];
        end
`ifdef IND_LEADING_ZERO_BLANK_EN
        begin
            logic allz;
            allz = 1'b1;
            // Walk down from the top digit; a digit blanks only while everything above it is zero too.
            for (int i = DIGITS - 1; i > 0; i--) begin
                allz = allz & (dbcd_q[4*i +: 4] == 4'd0);
                if ((idx_q == IW'(i)) && allz && !((dctl_q == CODE_D) && (i <= 2))) blank = 1'b1;
            end
        end
`endif
        if (dctl_q == CODE_D0) begin
            if (idx_q == IW'(DIGITS - 1)) glyph_d = GLYPH_E;
            else if (idx_q != '0)         glyph_d = GLYPH_R;
        end else if (!blank) begin
            glyph_d = bcd_to_seg(nib);
            if ((dctl_q == CODE_D) && (idx_q == IW'(2))) glyph_d[7] = 1'b0;
        end
    end

    always_ff @(posedge clk_IND or negedge rst_n_IND) begin
        if (!rst_n_IND) begin
            presc_q <= '0;
            idx_q   <= '0;
            seg_q   <= GLYPH_BLANK;
            an_q    <= '1;
        end else if (presc_q == PW'(SCAN_DIV - 1)) begin
            presc_q <= '0;
            seg_q   <= glyph_d;
            an_q    <= ~(DIGITS'(1) << idx_q);
            idx_q   <= (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + IW'(1);
        end else begin
            presc_q <= presc_q + PW'(1);
        end
    end

    assign seg       = seg_q;
    assign an        = an_q;
    assign minus_led = minus_q;
    assign busy      = cvt_busy;

endmodule

// File: tb/tb_ind_driver.sv
// Self-checking bench for ind_driver; expected glyphs come from a decimal model of the display.
module tb_ind_driver;

    localparam int IND_1    = 11;
    localparam int CONTROL  = 3;
    localparam int DIGITS   = 4;
    localparam int SCAN_DIV = 4;

    localparam logic [7:0] GLY [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                       8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

    logic                clk_IND   = 1'b0;
    logic                rst_n_IND = 1'b0;
    logic [IND_1-1:0]    ind_1     = '0;
    logic [CONTROL-1:0]  control   = '0;
    logic [7:0]          seg;
    logic [DIGITS-1:0]   an;
    logic                minus_led;
    logic                busy;

    int checks = 0;
    int errors = 0;
    int busy_rises = 0;
    bit tmo;
    logic [7:0] got [DIGITS];

    ind_driver #(
        .IND_1    (IND_1),
        .CONTROL  (CONTROL),
        .DIGITS   (DIGITS),
        .SCAN_DIV (SCAN_DIV)
    ) dut (
        .clk_IND   (clk_IND),
        .rst_n_IND (rst_n_IND),
        .ind_1     (ind_1),
        .control   (control),
        .seg       (seg),
        .an        (an),
        .minus_led (minus_led),
        .busy      (busy)
    );

    always #5 clk_IND = ~clk_IND;

    always @(posedge busy) busy_rises++;

    // Expected glyph for digit i of value val shown under control code code.
    function automatic logic [7:0] exp_seg(int val, int code, int i);
        int c;
        int p;
        logic [7:0] g;
        c = (code == 1 || code == 2 || code == 4) ? code : 0;
        p = 1;
        for (int k = 0; k < i; k++) p = p * 10;
        if (c == 2) return (i == DIGITS - 1) ? 8'h86 : ((i == 0) ? 8'hFF : 8'hAF);
        g = GLY[(val / p) % 10];
`ifdef IND_LEADING_ZERO_BLANK_EN
        if (i != 0 && val < p && !(c == 4 && i <= 2)) return 8'hFF;
`endif
        if (c == 4 && i == 2) g[7] = 1'b0;
        return g;
    endfunction

    task automatic wait_idle();
        int quiet;
        int n;
        quiet = 0;
        n = 0;
        tmo = 1'b0;
        while (quiet < 24) begin
            @(negedge clk_IND);
            quiet = busy ? 0 : quiet + 1;
            n++;
            if (n > 600) begin
                tmo = 1'b1;
                break;
            end
        end
    endtask

    task automatic scan_digits();
        for (int i = 0; i < DIGITS; i++) got[i] = 'x;
        repeat (2 * DIGITS * SCAN_DIV) begin
            @(negedge clk_IND);
            for (int i = 0; i < DIGITS; i++) begin
                if (an == ~(DIGITS'(1) << i)) got[i] = seg;
            end
        end
    endtask

    task automatic test_reset();
        bit saw_busy;
        rst_n_IND = 1'b0;
        ind_1 = '0;
        control = '0;
        repeat (3) @(negedge clk_IND);
        checks++;
        if ({seg, an, minus_led, busy} !== {8'hFF, 4'hF, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_values: seg=%h an=%b minus=%b busy=%b want seg=ff an=1111 minus=0 busy=0",
                     seg, an, minus_led, busy);
        end
        rst_n_IND = 1'b1;
        saw_busy = 1'b0;
        for (int c = 1; c <= SCAN_DIV; c++) begin
            @(negedge clk_IND);
            if (busy) saw_busy = 1'b1;
            if (c == SCAN_DIV - 1) begin
                checks++;
                if (an !== 4'hF) begin
                    errors++;
                    $display("FAIL reset_blank_before_wrap: an=%b want 1111", an);
                end
            end
        end
        checks++;
        if (an !== 4'b1110 || seg !== 8'hC0) begin
            errors++;
            $display("FAIL reset_first_wrap: an=%b seg=%b want an=1110 seg=11000000", an, seg);
        end
        scan_digits();
        for (int i = 0; i < DIGITS; i++) if (busy) saw_busy = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            checks++;
            if (got[i] !== exp_seg(0, 0, i)) begin
                errors++;
                $display("FAIL reset_digit%0d: seg=%b want %b", i, got[i], exp_seg(0, 0, i));
            end
        end
        checks++;
        if (saw_busy) begin
            errors++;
            $display("FAIL reset_no_busy: busy=1 want 0");
        end
    endtask

    task automatic test_max();
        int n;
        logic first;
        @(negedge clk_IND);
        ind_1 = 11'd2047;
        control = 3'd0;
        n = 0;
        first = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk_IND);
            if (k == 0) first = busy;
            if (busy) n++;
            else if (n > 0) break;
        end
        checks++;
        if (first !== 1'b1) begin
            errors++;
            $display("FAIL max_busy_start: busy=%b want 1", first);
        end
        checks++;
        if (n != 12) begin
            errors++;
            $display("FAIL max_busy_len: cycles=%0d want 12", n);
        end
        wait_idle();
        scan_digits();
        for (int i = 0; i < DIGITS; i++) begin
            checks++;
            if (got[i] !== exp_seg(2047, 0, i)) begin
                errors++;
                $display("FAIL max_digit%0d: seg=%b want %b", i, got[i], exp_seg(2047, 0, i));
            end
        end
        checks++;
        if (minus_led !== 1'b0) begin
            errors++;
            $display("FAIL max_minus: minus=%b want 0", minus_led);
        end
    endtask

    task automatic test_quotient();
        @(negedge clk_IND);
        ind_1 = 11'd5;
        control = 3'd4;
        wait_idle();
        checks++;
        if (tmo) begin
            errors++;
            $display("FAIL quot_timeout: busy still active want idle");
        end
        scan_digits();
        for (int i = 0; i < DIGITS; i++) begin
            checks++;
            if (got[i] !== exp_seg(5, 4, i)) begin
                errors++;
                $display("FAIL quot_digit%0d: seg=%b want %b", i, got[i], exp_seg(5, 4, i));
            end
        end
    endtask

    task automatic test_minus();
        @(negedge clk_IND);
        ind_1 = 11'd13;
        control = 3'd1;
        wait_idle();
        scan_digits();
        for (int i = 0; i < DIGITS; i++) begin
            checks++;
            if (got[i] !== exp_seg(13, 1, i)) begin
                errors++;
                $display("FAIL minus_digit%0d: seg=%b want %b", i, got[i], exp_seg(13, 1, i));
            end
        end
        checks++;
        if (minus_led !== 1'b1) begin
            errors++;
            $display("FAIL minus_led: minus=%b want 1", minus_led);
        end
        @(negedge clk_IND);
        control = 3'd2;
        wait_idle();
        scan_digits();
        for (int i = 0; i < DIGITS; i++) begin
            checks++;
            if (got[i] !== exp_seg(13, 2, i)) begin
                errors++;
                $display("FAIL err_digit%0d: seg=%b want %b", i, got[i], exp_seg(13, 2, i));
            end
        end
        checks++;
        if (minus_led !== 1'b0) begin
            errors++;
            $display("FAIL err_minus: minus=%b want 0", minus_led);
        end
    endtask

    task automatic test_back_to_back();
        int r0;
        int r;
        @(negedge clk_IND);
        control = 3'd0;
        r0 = busy_rises;
        ind_1 = 11'd100;
        repeat (3) @(negedge clk_IND);
        ind_1 = 11'd200;
        repeat (3) @(negedge clk_IND);
        ind_1 = 11'd300;
        wait_idle();
        r = busy_rises - r0;
        checks++;
        if (tmo || r < 2 || r > 3) begin
            errors++;
            $display("FAIL b2b_conversions: count=%0d timeout=%0d want 2..3 and no timeout", r, tmo);
        end
        scan_digits();
        for (int i = 0; i < DIGITS; i++) begin
            checks++;
            if (got[i] !== exp_seg(300, 0, i)) begin
                errors++;
                $display("FAIL b2b_digit%0d: seg=%b want %b", i, got[i], exp_seg(300, 0, i));
            end
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk_IND);
        ind_1 = 11'd7;
        control = 3'd1;
        wait_idle();
        ind_1 = 11'd1234;
        @(posedge clk_IND);
        repeat (5) @(posedge clk_IND);
        #2 rst_n_IND = 1'b0;
        #1;
        checks++;
        if ({seg, an, minus_led, busy} !== {8'hFF, 4'hF, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL midreset_values: seg=%h an=%b minus=%b busy=%b want seg=ff an=1111 minus=0 busy=0",
                     seg, an, minus_led, busy);
        end
        @(negedge clk_IND);
        rst_n_IND = 1'b1;
        wait_idle();
        scan_digits();
        for (int i = 0; i < DIGITS; i++) begin
            checks++;
            if (got[i] !== exp_seg(1234, 1, i)) begin
                errors++;
                $display("FAIL midreset_digit%0d: seg=%b want %b", i, got[i], exp_seg(1234, 1, i));
            end
        end
        checks++;
        if (minus_led !== 1'b1) begin
            errors++;
            $display("FAIL midreset_minus: minus=%b want 1", minus_led);
        end
    endtask

    task automatic test_random();
        int v;
        int c;
        for (int t = 0; t < 16; t++) begin
            v = int'($urandom_range(2047, 0));
            c = int'($urandom_range(7, 0));
            @(negedge clk_IND);
            ind_1 = IND_1'(v);
            control = CONTROL'(c);
            wait_idle();
            scan_digits();
            for (int i = 0; i < DIGITS; i++) begin
                checks++;
                if (got[i] !== exp_seg(v, c, i)) begin
                    errors++;
                    $display("FAIL rand_digit%0d: seg=%b want %b (val=%0d code=%0d)",
                             i, got[i], exp_seg(v, c, i), v, c);
                end
            end
            checks++;
            if (minus_led !== (c == 1)) begin
                errors++;
                $display("FAIL rand_minus: minus=%b want %b (val=%0d code=%0d)", minus_led, (c == 1), v, c);
            end
        end
    endtask

    initial begin
        test_reset();
        test_max();
        test_quotient();
        test_minus();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ind_driver.md
# ind_driver

Display stage directly downstream of the calculator ALU. Takes the ALU's registered result `ind_1` and its `control` code. Converts the 11-bit binary value to BCD with a sequential double-dabble engine. Drives a multiplexed, active-low 4-digit 7-segment indicator plus a sign LED, with decimal-point and error rendering.

## Interface
- `IND_1`, 11, result width from ALU
- `CONTROL`, 3, control code width
- `DIGITS`, 4, indicator digit count
- `SCAN_DIV`, 16, clock cycles each digit is held active (≥2)

- `clk_IND` in 1: single clock, all state on rising edge
- `rst_n_IND` in 1: reset, asynchronous, active-low
- `ind_1` in `IND_1`: unsigned result magnitude
- `control` in `CONTROL`: 0 = plus, 1 = minus, 2 = divide-by-zero, 4 = quotient ×100; other codes are treated as 0
- `seg` out 8: active-low segments; [0]=a … [6]=g, [7]=dp
- `an` out `DIGITS`: active-low digit enables; `an[0]` is the units (rightmost) digit
- `minus_led` out 1: high while the displayed value is negative
- `busy` out 1: high while a conversion is in progress

## Operation
- Capture registers `cap_val`/`cap_ctl` reset to 0. Display BCD registers reset to 0, and display control resets to 0.
- Change detect: in IDLE, if `{ind_1,control}` ≠ `{cap_val,cap_ctl}`, load the capture registers and enter SHIFT. Inputs that change during a conversion are ignored until IDLE. The next compare then triggers a fresh conversion, so the last value always wins.
- FSM states:
  - IDLE→SHIFT on change.
  - SHIFT runs exactly `IND_1` cycles. Each cycle adds 3 to every BCD nibble ≥5, then shifts left one bit with the binary MSB entering.
  - SHIFT→DONE.
  - DONE commits BCD (16 bits, 4 nibbles; max 2047) and `cap_ctl` to the display registers, then →IDLE.
- `busy` = 1 in SHIFT and DONE.
- Rendering, per digit `i`:
  - Code 2: the pattern reads "Err" plus a blank. Digit 3 = E (1000_0110), digits 2 and 1 = r (1010_1111), digit 0 = blank (1111_1111). `minus_led` = 0.
  - Code 4: dp lit on digit 2 (value shown as xx.xx).
  - Code 1: `minus_led` = 1. Otherwise `minus_led` = 0.
  - Digit glyphs: 0 = 1100_0000, 1 = 1111_1001, 2 = 1010_0100, 3 = 1011_0000, 4 = 1001_1001, 5 = 1001_0010, 6 = 1000_0010, 7 = 1111_1000, 8 = 1000_0000, 9 = 1001_0000. dp is bit 7, cleared when lit.
- Scan: the prescaler counts 0..`SCAN_DIV`-1. On wrap, the digit index advances 0→1→…→`DIGITS`-1→0.
- `an` is one-hot-low at the index. `seg` is the rendered glyph for that index and is registered with `an`.

## Timing
- Reset values: `seg` = 8'hFF, `an` = all ones, `minus_led` = 0, `busy` = 0, FSM = IDLE, prescaler = 0, digit index = 0.
- `an`/`seg` stay blank until the first prescaler wrap. That wrap lights digit 0, and cycle `SCAN_DIV` after reset release shows "0".
- Input change sampled at edge N:
  - Capture at edge N (IDLE); `busy` is high from N+1.
  - SHIFT spans edges N+1..N+11, DONE at N+12, IDLE at N+13.
  - The display registers hold the new value from edge N+12. The glyph appears at the next digit slot that uses it.
- Full refresh period is `DIGITS`·`SCAN_DIV` cycles. The scan is never interrupted by conversions.
- Reset asserted mid-conversion: everything returns to reset values immediately. The partial BCD result is discarded.

## Configuration
- `IND_LEADING_ZERO_BLANK_EN`:
  - Defined: leading zero digits render blank. Digit 0 is never blanked. For code 4, digits 2..0 are never blanked, so 5 shows "0.05".
  - Undefined: all digits always render (5 → "0005"). Code 2 is unaffected either way.

## Structure
- Package `ind_pkg`:
  - control code constants `CODE_P`=0, `CODE_M`=1, `CODE_D0`=2, `CODE_D`=4
  - FSM state enum
  - glyph constants (digits, E, r, blank)
  - a BCD-nibble→segment function
- Sub-module `bin2bcd_seq`: owns the double-dabble SHIFT loop. It has a start/done handshake and `IND_1`/`DIGITS` parameters.
- The top holds change detect, display registers, prescaler, scan and rendering.

## Test plan
1. Reset release with `ind_1`=0, `control`=0, `SCAN_DIV`=4. At cycle 4, `an`=1110 and `seg`=1100_0000. `busy` never rises. With blanking enabled, digits 1–3 are 1111_1111.
2. `ind_1`=2047, `control`=0. `busy` is high for 12 cycles. Scan then shows 7, 4, 0, 2 on `an[0..3]` and `minus_led`=0.
3. `ind_1`=5, `control`=4. Digit 2 `seg`=0100_0000, digit 1 = 1100_0000, digit 0 = 1001_0010. Digit 3 is blank with blanking enabled, 1100_0000 without.
4. `ind_1`=13, `control`=1. `minus_led`=1 and digits show 3, 1. Then `control`=2: "Err" pattern and `minus_led`=0.
5. Change `ind_1` 100→200→300 at 3-cycle intervals during a conversion. The final display is 300, reached after at most two extra conversions.
6. Assert `rst_n_IND` low at SHIFT cycle 5 of 1234. Outputs immediately return to reset values. After release, the input is reconverted from IDLE and shows 1234.
